// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard, flush and memory-freeze control with timeout watchdog.
// Define HAZARD_FORWARDING_EN to stall on load-use only (forwarding build).
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             flush,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           state_q;
  logic [WW-1:0]    wait_q;
  logic             err_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] fcnt_q;

  logic exe_hit;
  logic mem_hit;
  logic raw;

  assign exe_hit = exe_wb_en &
                   ((src1 == exe_dest) |
                    (two_src & (src2 == exe_dest)));
  assign mem_hit = mem_wb_en &
                   ((src1 == mem_dest) |
                    (two_src & (src2 == mem_dest)));

`ifdef HAZARD_FORWARDING_EN
  // MEM results are forwarded; only a load in EXE cannot be bypassed
  assign raw = exe_hit & exe_mem_read;
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
`else
  assign raw = exe_hit | mem_hit;
  logic unused_mem_read;
  assign unused_mem_read = exe_mem_read;
`endif

  assign freeze = mem_req & ~mem_ready;
  assign flush  = branch_taken & ~freeze;
  assign hazard = raw & ~freeze & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (freeze) begin
            state_q <= S_WAIT;
            wait_q  <= WW'(1);
          end
        end
        S_WAIT: begin
          if (!freeze) begin
            state_q <= S_RUN;
            wait_q  <= '0;
          end else if (wait_q == WW'(MEM_TIMEOUT)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= S_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (hazard && !(&hcnt_q))
        hcnt_q <= hcnt_q + 1'b1;
      if (freeze && !(&fcnt_q))
        fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign mem_err    = err_q;
  assign hazard_cnt = hcnt_q;
  assign freeze_cnt = fcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a CNT_W=4 copy checks saturation.
// Expectations follow HAZARD_FORWARDING_EN when the bench is built with it.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, exe_dest, mem_dest;
  logic        two_src, exe_wb_en, exe_mem_read;
  logic        mem_wb_en, branch_taken, mem_req, mem_ready;

  logic        hazard, flush, freeze, mem_err;
  logic [15:0] hazard_cnt, freeze_cnt;
  logic        s_hazard, s_flush, s_freeze, s_mem_err;
  logic [3:0]  s_hazard_cnt, s_freeze_cnt;

  int tests = 0;
  int fails = 0;
  int exp_h;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hazard), .flush(flush), .freeze(freeze),
    .mem_err(mem_err),
    .hazard_cnt(hazard_cnt), .freeze_cnt(freeze_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(s_hazard), .flush(s_flush), .freeze(s_freeze),
    .mem_err(s_mem_err),
    .hazard_cnt(s_hazard_cnt), .freeze_cnt(s_freeze_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
    exe_wb_en = 1'b0; exe_dest = 4'd0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = 4'd0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    chk("rst_err", mem_err, 0);
    chk("rst_hcnt", hazard_cnt, 0);
    chk("rst_fcnt", freeze_cnt, 0);
    chk("rst_haz", hazard, 0);

    // combinational path live in reset, counters frozen
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; #1;
    chk("rst_haz_follow", hazard, FWD ? 0 : 1);
    mem_req = 1'b1; #1;
    chk("rst_frz_follow", freeze, 1);
    tick();
    chk("rst_hcnt_hold", hazard_cnt, 0);
    chk("rst_fcnt_hold", freeze_cnt, 0);
    idle();
    rst = 1'b1; #1;
    exp_h = 0;

    // plain EXE RAW, not a load
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; #1;
    chk("exe_raw", hazard, FWD ? 0 : 1);
    chk("exe_raw_flush", flush, 0);
    tick();
    exp_h += FWD ? 0 : 1;
    chk("exe_raw_cnt", hazard_cnt, exp_h);

    // MEM-stage RAW
    idle();
    src1 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1; #1;
    chk("mem_raw", hazard, FWD ? 0 : 1);
    tick();
    exp_h += FWD ? 0 : 1;
    chk("mem_raw_cnt", hazard_cnt, exp_h);

    // writeback disabled: no dependency
    idle();
    src1 = 4'd7; mem_dest = 4'd7; exe_dest = 4'd7; #1;
    chk("no_wb", hazard, 0);

    // load-use on src2
    idle();
    src1 = 4'd1; src2 = 4'd5; two_src = 1'b1;
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_read = 1'b1; #1;
    chk("lu_src2", hazard, 1);
    tick();
    exp_h += 1;
    chk("lu_src2_cnt", hazard_cnt, exp_h);
    two_src = 1'b0; #1;
    chk("lu_src2_unused", hazard, 0);

    // branch beats load-use
    two_src = 1'b1; branch_taken = 1'b1; #1;
    chk("br_flush", flush, 1);
    chk("br_haz", hazard, 0);
    tick();
    chk("br_hcnt", hazard_cnt, exp_h);

    // freeze suppresses both flush and hazard
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk("frz_flush", flush, 0);
    chk("frz_haz", hazard, 0);
    chk("frz_frz", freeze, 1);
    tick();
    chk("frz_fcnt", freeze_cnt, 1);
    chk("frz_hcnt", hazard_cnt, exp_h);
    mem_ready = 1'b1; #1;
    chk("frz_rel_flush", flush, 1);

    // short memory stall
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_frz", freeze, 1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("stall_rel", freeze, 0);
    tick();
    chk("stall_fcnt", freeze_cnt, 4);
    chk("stall_err", mem_err, 0);
    // back in RUN: a fresh 15-cycle stall must not time out
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) tick();
    mem_req = 1'b0; #1;
    tick();
    chk("stall2_err", mem_err, 0);

    // timeout
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) tick();
    chk("to_pre", mem_err, 0);
    tick();
    chk("to_set", mem_err, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("to_fcnt", freeze_cnt, 20);
    chk("to_fcnt_sat", s_freeze_cnt, 15);
    mem_ready = 1'b1; #1;
    chk("to_frz_rel", freeze, 0);
    tick(); tick();
    chk("to_sticky", mem_err, 1);
    mem_ready = 1'b0; #1;
    chk("err_frz", freeze, 1);
    rst = 1'b0; #1;
    chk("to_rst_async", mem_err, 0);
    idle();
    rst = 1'b1; #1;
    tick();
    chk("to_rst_clr", mem_err, 0);
    chk("to_rst_fcnt", freeze_cnt, 0);

    // hazard counter saturation on the 4-bit copy
    do_reset();
    src1 = 4'd9; exe_dest = 4'd9;
    exe_wb_en = 1'b1; exe_mem_read = 1'b1; #1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_hcnt", s_hazard_cnt, 15);
    chk("sat_hcnt_wide", hazard_cnt, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
